// File: rtl/rv_exc_pkg.sv
// Shared exception-unit definitions: cause codes, FSM state encoding and default trap vector.
package rv_exc_pkg;

   localparam int unsigned CAUSE_W     = 4;
   localparam int unsigned FLUSH_CNT_W = 3;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 4'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_EXT_IRQ = 4'd11;

   localparam logic [31:0] TRAP_VECTOR_DFLT = 32'h0000_0100;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLUSH    = 3'd1,
      REDIRECT = 3'd2,
      HANDLER  = 3'd3,
      RETURN   = 3'd4,
      HALT     = 3'd5
   } exc_state_t;

endpackage

// File: rtl/exception_unit_if.sv
// EX-stage exception fields in, pipeline control / trap CSRs out.
interface exception_unit_if
   import rv_exc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) ();

   logic               ex_valid;
   logic               ex_opinvalid;
   logic               ex_mret;
   logic [XLEN-1:0]    ex_pc;
   logic [XLEN-1:0]    ex_idata;
   logic               irq;

   logic               irq_ack;
   logic               flush;
   logic               stall;
   logic               pc_redirect;
   logic [XLEN-1:0]    pc_target;
   logic [XLEN-1:0]    epc;
   logic [CAUSE_W-1:0] cause;
   logic [XLEN-1:0]    badinstr;
   logic               in_handler;
   logic               double_fault;

   modport master (
      output ex_valid, ex_opinvalid, ex_mret, ex_pc, ex_idata, irq,
      input  irq_ack, flush, stall, pc_redirect, pc_target, epc, cause,
             badinstr, in_handler, double_fault
   );

   modport slave (
      input  ex_valid, ex_opinvalid, ex_mret, ex_pc, ex_idata, irq,
      output irq_ack, flush, stall, pc_redirect, pc_target, epc, cause,
             badinstr, in_handler, double_fault
   );

endinterface

// File: rtl/exception_unit.sv
// Trap/return sequencer for the EX stage: saves EPC/cause, flushes and stalls the
// pipeline for FLUSH_CYCLES, then redirects fetch to the trap vector or back to EPC.
module exception_unit
   import rv_exc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DFLT),
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   exception_unit_if.slave bus
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   exc_state_t             state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]        epc_q, epc_d;
   logic [XLEN-1:0]        badinstr_q, badinstr_d;
   logic [XLEN-1:0]        pc_target_q, pc_target_d;
   logic [CAUSE_W-1:0]     cause_q, cause_d;
   logic                   irq_ack_q, irq_ack_d;
   logic                   flush_q, flush_d;
   logic                   stall_q, stall_d;
   logic                   pc_redirect_q, pc_redirect_d;
   logic                   in_handler_q, in_handler_d;
   logic                   double_fault_q, double_fault_d;
   logic                   exc_c, irq_c, illegal_c, mret_c;

   // mret outside the handler is treated as an illegal instruction.
   assign illegal_c = bus.ex_valid & bus.ex_opinvalid;
   assign mret_c    = bus.ex_valid & bus.ex_mret;
   assign exc_c     = illegal_c | mret_c;
   assign irq_c     = bus.ex_valid & bus.irq & ~bus.ex_opinvalid;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      epc_d          = epc_q;
      cause_d        = cause_q;
      badinstr_d     = badinstr_q;
      in_handler_d   = in_handler_q;
      double_fault_d = double_fault_q;
      irq_ack_d      = 1'b0;
      flush_d        = 1'b0;
      stall_d        = 1'b0;
      pc_redirect_d  = 1'b0;
      pc_target_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (exc_c) begin
               epc_d      = bus.ex_pc;
               cause_d    = CAUSE_ILLEGAL;
               badinstr_d = bus.ex_idata;
               flush_d    = 1'b1;
               stall_d    = 1'b1;
               cnt_d      = FLUSH_LOAD;
               state_d    = FLUSH;
            end else if (irq_c) begin
               epc_d      = bus.ex_pc;
               cause_d    = CAUSE_EXT_IRQ;
               badinstr_d = '0;
               irq_ack_d  = 1'b1;
               flush_d    = 1'b1;
               stall_d    = 1'b1;
               cnt_d      = FLUSH_LOAD;
               state_d    = FLUSH;
            end
         end
         FLUSH: begin
            flush_d = 1'b1;
            if (cnt_q == '0) begin
               pc_redirect_d = 1'b1;
               pc_target_d   = TRAP_VECTOR;
               state_d       = REDIRECT;
            end else begin
               stall_d = 1'b1;
               cnt_d   = cnt_q - FLUSH_CNT_W'(1);
            end
         end
         REDIRECT: begin
            in_handler_d = 1'b1;
            state_d      = HANDLER;
         end
         HANDLER: begin
            // irq deliberately not sampled here: no nested traps.
            if (illegal_c) begin
               double_fault_d = 1'b1;
               flush_d        = 1'b1;
               stall_d        = 1'b1;
               state_d        = HALT;
            end else if (mret_c) begin
               pc_redirect_d = 1'b1;
               pc_target_d   = epc_q;
               flush_d       = 1'b1;
               state_d       = RETURN;
            end
         end
         RETURN: begin
            in_handler_d = 1'b0;
            cause_d      = CAUSE_NONE;
            state_d      = IDLE;
         end
         HALT: begin
            flush_d = 1'b1;
            stall_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         epc_q          <= '0;
         cause_q        <= '0;
         badinstr_q     <= '0;
         in_handler_q   <= 1'b0;
         double_fault_q <= 1'b0;
         irq_ack_q      <= 1'b0;
         flush_q        <= 1'b0;
         stall_q        <= 1'b0;
         pc_redirect_q  <= 1'b0;
         pc_target_q    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         epc_q          <= epc_d;
         cause_q        <= cause_d;
         badinstr_q     <= badinstr_d;
         in_handler_q   <= in_handler_d;
         double_fault_q <= double_fault_d;
         irq_ack_q      <= irq_ack_d;
         flush_q        <= flush_d;
         stall_q        <= stall_d;
         pc_redirect_q  <= pc_redirect_d;
         pc_target_q    <= pc_target_d;
      end
   end

   assign bus.irq_ack      = irq_ack_q;
   assign bus.flush        = flush_q;
   assign bus.stall        = stall_q;
   assign bus.pc_redirect  = pc_redirect_q;
   assign bus.pc_target    = pc_target_q;
   assign bus.epc          = epc_q;
   assign bus.cause        = cause_q;
   assign bus.badinstr     = badinstr_q;
   assign bus.in_handler   = in_handler_q;
   assign bus.double_fault = double_fault_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed and randomized checks of exception_unit against a cycle-timestamp trap model.
module tb_exception_unit;
   import rv_exc_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int          FC   = 2;
   localparam logic [31:0] TV   = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;

   exception_unit_if #(.XLEN(XLEN)) bus ();

   exception_unit #(.XLEN(XLEN), .TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Model: an episode is described by the cycle numbers at which its events happened.
   int          trap_at, ret_at, halt_from;
   bit          trap_irq;
   logic [31:0] m_epc, m_bad;
   logic [3:0]  m_cause;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      trap_at = -1; ret_at = -1; halt_from = -1; trap_irq = 1'b0;
      m_epc = '0; m_bad = '0; m_cause = '0;
   endtask

   // Applies the inputs seen at the edge that ends cycle cyc.
   task automatic model_update();
      if (trap_at < 0) begin
         if (bus.ex_valid && (bus.ex_opinvalid || bus.ex_mret)) begin
            trap_at = cyc; trap_irq = 1'b0;
            m_epc = bus.ex_pc; m_cause = 4'd2; m_bad = bus.ex_idata;
         end else if (bus.ex_valid && bus.irq) begin
            trap_at = cyc; trap_irq = 1'b1;
            m_epc = bus.ex_pc; m_cause = 4'd11; m_bad = '0;
         end
      end else if (cyc >= trap_at + FC + 2 && ret_at < 0 && halt_from < 0) begin
         if (bus.ex_valid && bus.ex_opinvalid) halt_from = cyc + 1;
         else if (bus.ex_valid && bus.ex_mret) ret_at = cyc;
      end else if (ret_at >= 0 && cyc == ret_at + 1) begin
         trap_at = -1; ret_at = -1; m_cause = '0;
      end
   endtask

   task automatic compare_all();
      logic        e_flush, e_stall, e_redir, e_ack, e_inh, e_df;
      logic [31:0] e_tgt;
      int          k;
      e_flush = 0; e_stall = 0; e_redir = 0; e_ack = 0; e_tgt = '0;
      e_df  = (halt_from >= 0 && cyc >= halt_from);
      e_inh = (trap_at >= 0 && cyc >= trap_at + FC + 2);
      if (e_df) begin
         e_flush = 1; e_stall = 1;
      end else if (trap_at >= 0) begin
         k = cyc - trap_at;
         if (k >= 1 && k <= FC) begin e_flush = 1; e_stall = 1; end
         if (k == 1 && trap_irq) e_ack = 1;
         if (k == FC + 1) begin e_redir = 1; e_tgt = TV; e_flush = 1; end
         if (ret_at >= 0 && cyc == ret_at + 1) begin e_redir = 1; e_tgt = m_epc; e_flush = 1; end
      end
      check("flush",        32'(bus.flush),        32'(e_flush));
      check("stall",        32'(bus.stall),        32'(e_stall));
      check("pc_redirect",  32'(bus.pc_redirect),  32'(e_redir));
      check("pc_target",    bus.pc_target,         e_tgt);
      check("irq_ack",      32'(bus.irq_ack),      32'(e_ack));
      check("in_handler",   32'(bus.in_handler),   32'(e_inh));
      check("double_fault", 32'(bus.double_fault), 32'(e_df));
      check("epc",          bus.epc,               m_epc);
      check("cause",        32'(bus.cause),        32'(m_cause));
      check("badinstr",     bus.badinstr,          m_bad);
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_update();
      cyc++;
      #1 compare_all();
   endtask

   task automatic drive(input logic v, input logic op, input logic mr,
                        input logic [31:0] pc, input logic [31:0] id, input logic iq);
      bus.ex_valid = v; bus.ex_opinvalid = op; bus.ex_mret = mr;
      bus.ex_pc = pc; bus.ex_idata = id; bus.irq = iq;
      step();
   endtask

   task automatic async_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_df",    32'(bus.double_fault), 32'd0);
      compare_all();
      bus.ex_valid = 1'b0; bus.irq = 1'b0;
      step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic v, op, mr, iq;
      rst = 1'b1;
      bus.ex_valid = 0; bus.ex_opinvalid = 0; bus.ex_mret = 0;
      bus.ex_pc = '0; bus.ex_idata = '0; bus.irq = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 compare_all();
      @(negedge clk);
      rst = 1'b0;

      // Illegal opcode
      drive(1, 1, 0, 32'h40, 32'hFFFF_FFFF, 0);
      check("ill_epc", bus.epc, 32'h40);
      check("ill_cause", 32'(bus.cause), 32'd2);
      check("ill_bad", bus.badinstr, 32'hFFFF_FFFF);
      check("ill_flush1", 32'(bus.flush), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      check("ill_flush2", 32'(bus.flush), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      check("ill_redir", 32'(bus.pc_redirect), 32'd1);
      check("ill_target", bus.pc_target, 32'h100);
      drive(0, 0, 0, 0, 0, 0);
      check("ill_inh", 32'(bus.in_handler), 32'd1);
      drive(1, 0, 1, 32'h104, 32'h3020_0073, 0);
      check("ret_target", bus.pc_target, 32'h40);
      drive(0, 0, 0, 0, 0, 0);

      // External interrupt and return
      drive(1, 0, 0, 32'h80, 32'h13, 1);
      check("irq_ack", 32'(bus.irq_ack), 32'd1);
      check("irq_cause", 32'(bus.cause), 32'd11);
      check("irq_epc", bus.epc, 32'h80);
      drive(0, 0, 0, 0, 0, 0);
      check("irq_ack_pulse", 32'(bus.irq_ack), 32'd0);
      repeat (3) drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 32'h110, 32'h3020_0073, 0);
      check("irq_ret_target", bus.pc_target, 32'h80);
      drive(0, 0, 0, 0, 0, 0);
      check("irq_ret_inh", 32'(bus.in_handler), 32'd0);

      // Simultaneous irq and illegal opcode, irq held through the handler
      drive(1, 1, 0, 32'h200, 32'hDEAD_BEEF, 1);
      check("both_cause", 32'(bus.cause), 32'd2);
      check("both_ack", 32'(bus.irq_ack), 32'd0);
      repeat (4) drive(0, 0, 0, 0, 0, 1);
      drive(1, 0, 1, 32'h120, 32'h3020_0073, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 32'h300, 32'h13, 1);
      check("late_irq_cause", 32'(bus.cause), 32'd11);
      check("late_irq_ack", 32'(bus.irq_ack), 32'd1);
      repeat (3) drive(0, 0, 0, 0, 0, 1);
      repeat (4) drive(1, 0, 0, 32'h400, 32'h13, 1);
      check("hnd_epc", bus.epc, 32'h300);
      drive(1, 1, 0, 32'h410, 32'hFFFF_FFFF, 1);
      check("df_set", 32'(bus.double_fault), 32'd1);
      repeat (5) drive(1, 0, 1, 32'h420, 32'h13, 0);
      check("df_stall", 32'(bus.stall), 32'd1);
      async_reset();

      // Reset during FLUSH, then a bubble carrying opinvalid
      drive(1, 1, 0, 32'h500, 32'h1234_5678, 0);
      async_reset();
      check("rstf_epc", bus.epc, 32'h0);
      drive(0, 1, 0, 32'h600, 32'hFFFF_FFFF, 1);
      check("bubble_flush", 32'(bus.flush), 32'd0);
      check("bubble_ack", 32'(bus.irq_ack), 32'd0);

      // Randomized traffic
      iq = 0;
      for (int i = 0; i < 3000; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         op = ($urandom_range(0, 15) == 0);
         mr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) iq = ~iq;
         drive(v, op, mr, $urandom() & 32'hFFFF_FFFC, $urandom(), iq);
         if ($urandom_range(0, 299) == 0 || (halt_from >= 0 && $urandom_range(0, 19) == 0))
            async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
